bill_dispense_ctrl: RTL and testbench
=====================================

# bill_dispense_ctrl

Sequential dispense controller that sits directly downstream of the bill-selection decoder. It takes the decoded 8-bit bill value and the decoder's invalid-selection flag, plus a bill quantity. On a request it checks the total against a held account balance and debits the balance. It then emits one bill-eject pulse per note at a fixed spacing, and reports completion or a coded error.

## Interface
- `BAL_W`, 16: balance register width (bits).
- `INIT_BALANCE`, 16'd500: balance value loaded at reset.
- `GAP_CYCLES`, 2: idle cycles between consecutive `bill_pulse` outputs (≥1).
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `amount` in 8: bill value from the selection decoder (1/5/10/20/50/100; 0 = none).
- `invalid` in 1: decoder invalid-selection flag (multiple switches set).
- `qty` in 4: number of bills requested (0–15).
- `req` in 1: withdrawal request, sampled only in IDLE.
- `dep_en` in 1: deposit strobe, sampled only in IDLE when `req`=0.
- `dep_amt` in 8: deposit value added to the balance.
- `busy` out 1: high in every state except IDLE.
- `bill_pulse` out 1: one-cycle eject strobe, one per bill.
- `bill_val` out 8: latched bill value, valid while `busy`.
- `remaining` out 4: bills still to eject.
- `done` out 1: one-cycle success strobe.
- `err` out 1: one-cycle failure strobe.
- `err_code` out 2: 0 none, 1 invalid selection, 2 zero amount/qty, 3 insufficient funds; held until next `req` accept.
- `balance` out BAL_W: current balance.

## Operation
- The FSM has six states: IDLE, CHECK, EJECT, GAP, DONE, ERR.
- IDLE with `req`=1: latch `amount`→`bill_val`, `qty`→`remaining`, `invalid`, clear `err_code`, go to CHECK.
- IDLE with `req`=0 and `dep_en`=1: `balance` ← `balance` + `dep_amt`, saturating at 2^BAL_W−1. A deposit and a request in the same cycle: the request wins and the deposit is ignored.
- CHECK evaluates in priority order; the first matching row applies:
  - Latched invalid → ERR, code 1.
  - `bill_val`=0 or `remaining`=0 → ERR, code 2.
  - total > `balance` → ERR, code 3.
  - Otherwise `balance` ← `balance` − total, go to EJECT.
- total = `bill_val` × `remaining`, computed 12 bits wide (max 1500). The compare is done zero-extended to max(12, BAL_W) bits.
- EJECT: `bill_pulse`=1 for this cycle and `remaining` decrements.
  - If the value before the decrement was 1 → DONE.
  - Otherwise → GAP.
- GAP: count GAP_CYCLES cycles, then → EJECT.
- DONE: `done`=1 for one cycle, then → IDLE.
- ERR: `err`=1 for one cycle, then → IDLE. The balance is unchanged.
- Inputs other than `rst_n` are ignored while `busy`. `req` held high re-triggers on the first IDLE cycle after DONE/ERR.

## Timing
- Reset (`rst_n`=0 at a rising edge) applies in any state, including mid-dispense. It gives:
  - state IDLE;
  - `balance`=INIT_BALANCE;
  - `busy`, `bill_pulse`, `done`, `err` = 0;
  - `bill_val`=0, `remaining`=0, `err_code`=0.
- A debit already applied before a mid-dispense reset is lost (balance reloads).
- All outputs are registered.
- `req` is sampled at edge 0 and `busy` is high from cycle 1.
- CHECK occupies cycle 1, and the debited `balance` is visible from cycle 2.
- Bill k (1-based) pulses in cycle 2 + (k−1)(GAP_CYCLES+1).
- `done` is high in the cycle after the last pulse, and `busy` drops the cycle after that.
- Error path: `err` is high in cycle 2 and `busy` drops in cycle 3.
- A deposit is visible on `balance` the cycle after `dep_en`.

## Test plan
- Reset, GAP_CYCLES=2, `amount`=20, `qty`=3, `req` at cycle 0. Required: `bill_pulse` in cycles 2, 5, 8; `remaining` 3→2→1→0; `done` in cycle 9; `balance` 500→440 in cycle 2.
- `invalid`=1 with `amount`=0, `qty`=2. Required: `err` in cycle 2, `err_code`=1, `balance` stays 500, no `bill_pulse`.
- `amount`=100, `qty`=6 (600 > 500). Required: `err_code`=3 and the balance unchanged. Then `dep_en` with `dep_amt`=100 gives `balance`=600; repeating the request succeeds with 6 pulses and `balance`=0.
- `qty`=0 with `amount`=50 → `err_code`=2. Separately, `req` and `dep_en` asserted in the same cycle → request accepted, deposit dropped.
- `rst_n` low during the second GAP of a 4-bill withdrawal. Required: next cycle IDLE, `balance`=500, all strobes 0, no further pulses.
- Balance at 65500 with deposit 100 → `balance` saturates at 65535.

Source files
------------

// File: rtl/bill_dispense_ctrl.sv
// Bill dispense controller: checks a request against the held balance,
// debits it, then ejects one bill per pulse with a fixed idle gap between
// pulses. Reports completion or a coded error with one-cycle strobes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting; accepts a request or a deposit
// S_CHECK | validates latched request, debits balance on success
// S_EJECT | one bill_pulse cycle, decrements remaining
// S_GAP   | idle spacing between pulses (GAP_CYCLES cycles)
// S_DONE  | one-cycle success strobe
// S_ERR   | one-cycle failure strobe, balance untouched
module bill_dispense_ctrl #(
   parameter int                BAL_W        = 16,
   parameter logic [BAL_W-1:0]  INIT_BALANCE = BAL_W'(500),
   parameter int                GAP_CYCLES   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       amount,
   input  logic             invalid,
   input  logic [3:0]       qty,
   input  logic             req,
   input  logic             dep_en,
   input  logic [7:0]       dep_amt,
   output logic             busy,
   output logic             bill_pulse,
   output logic [7:0]       bill_val,
   output logic [3:0]       remaining,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [BAL_W-1:0] balance
);

   localparam int CMP_W = (BAL_W > 12) ? BAL_W : 12;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_EJECT,
      S_GAP,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state, state_nx;
   logic [BAL_W-1:0] bal_nx;
   logic [7:0]       val_nx;
   logic [3:0]       rem_nx;
   logic             inv_q, inv_nx;
   logic [1:0]       code_nx;
   logic [GAP_W-1:0] gap_cnt, gap_nx;

   logic [11:0]      total;
   logic [CMP_W-1:0] total_ext;
   logic [CMP_W-1:0] bal_ext;
   logic [BAL_W:0]   dep_sum;

   assign total     = {4'b0, bill_val} * {8'b0, remaining};
   assign total_ext = CMP_W'(total);
   assign bal_ext   = CMP_W'(balance);
   assign dep_sum   = {1'b0, balance} + {{(BAL_W-7){1'b0}}, dep_amt};

   // Register state, datapath and strobes; strobes are decoded from next state
   // so every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         balance    <= INIT_BALANCE;
         bill_val   <= '0;
         remaining  <= '0;
         inv_q      <= 1'b0;
         err_code   <= '0;
         gap_cnt    <= '0;
         busy       <= 1'b0;
         bill_pulse <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         balance    <= bal_nx;
         bill_val   <= val_nx;
         remaining  <= rem_nx;
         inv_q      <= inv_nx;
         err_code   <= code_nx;
         gap_cnt    <= gap_nx;
         busy       <= (state_nx != S_IDLE);
         bill_pulse <= (state_nx == S_EJECT);
         done       <= (state_nx == S_DONE);
         err        <= (state_nx == S_ERR);
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_nx = state;
      bal_nx   = balance;
      val_nx   = bill_val;
      rem_nx   = remaining;
      inv_nx   = inv_q;
      code_nx  = err_code;
      gap_nx   = gap_cnt;
      case (state)
         S_IDLE: begin
            if (req) begin
               val_nx   = amount;
               rem_nx   = qty;
               inv_nx   = invalid;
               code_nx  = 2'd0;
               state_nx = S_CHECK;
            end else if (dep_en) begin
               bal_nx = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
            end
         end
         S_CHECK: begin
            if (inv_q) begin
               code_nx  = 2'd1;
               state_nx = S_ERR;
            end else if (bill_val == 8'd0 || remaining == 4'd0) begin
               code_nx  = 2'd2;
               state_nx = S_ERR;
            end else if (total_ext > bal_ext) begin
               code_nx  = 2'd3;
               state_nx = S_ERR;
            end else begin
               // total never exceeds balance here, so the slice loses nothing
               bal_nx   = balance - total_ext[BAL_W-1:0];
               state_nx = S_EJECT;
            end
         end
         S_EJECT: begin
            rem_nx = remaining - 4'd1;
            if (remaining == 4'd1) begin
               state_nx = S_DONE;
            end else begin
               gap_nx   = GAP_LOAD;
               state_nx = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) begin
               state_nx = S_EJECT;
            end else begin
               gap_nx = gap_cnt - 1'b1;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bill_dispense_ctrl.sv
// Directed bench for bill_dispense_ctrl: cycle-exact withdrawal timing,
// a table of request/deposit transactions, mid-dispense reset and
// balance saturation.
module tb_bill_dispense_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  amount;
   logic        invalid;
   logic [3:0]  qty;
   logic        req;
   logic        dep_en;
   logic [7:0]  dep_amt;
   logic        busy;
   logic        bill_pulse;
   logic [7:0]  bill_val;
   logic [3:0]  remaining;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] balance;

   int checks = 0;
   int errors = 0;

   bill_dispense_ctrl #(
      .BAL_W        (16),
      .INIT_BALANCE (16'd500),
      .GAP_CYCLES   (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .amount     (amount),
      .invalid    (invalid),
      .qty        (qty),
      .req        (req),
      .dep_en     (dep_en),
      .dep_amt    (dep_amt),
      .busy       (busy),
      .bill_pulse (bill_pulse),
      .bill_val   (bill_val),
      .remaining  (remaining),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .balance    (balance)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          do_rst;
      bit          rq;
      bit          dep;
      bit          inv;
      logic [7:0]  amt;
      logic [3:0]  q;
      logic [7:0]  damt;
      logic [1:0]  exp_code;
      int          exp_pulses;
      bit          exp_done;
      bit          exp_err;
      logic [15:0] exp_bal;
   } vec_t;

   vec_t vecs [12];

   int exp_pulse [10] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
   int exp_done  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   int exp_busy  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
   int exp_rem   [10] = '{3, 3, 2, 2, 2, 1, 1, 1, 0, 0};
   int exp_bal   [10] = '{500, 440, 440, 440, 440, 440, 440, 440, 440, 440};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // advance one edge, then settle so outputs are sampled away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic idle_inputs();
      req = 1'b0; dep_en = 1'b0; invalid = 1'b0;
      amount = 8'd0; qty = 4'd0; dep_amt = 8'd0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  pulses;
      bit  seen_done;
      bit  seen_err;
      bit  finished;
      if (v.do_rst) do_reset();
      req = v.rq; dep_en = v.dep; invalid = v.inv;
      amount = v.amt; qty = v.q; dep_amt = v.damt;
      tick();
      idle_inputs();
      pulses = 0; seen_done = 0; seen_err = 0; finished = 0;
      if (v.rq) begin
         for (int c = 0; c < 100; c++) begin
            tick();
            if (bill_pulse) pulses++;
            if (done) seen_done = 1;
            if (err) seen_err = 1;
            if (!busy) begin
               finished = 1;
               break;
            end
         end
         chk($sformatf("v%0d_finished", idx), 32'(finished), 32'd1);
      end
      chk($sformatf("v%0d_pulses", idx), 32'(pulses), 32'(v.exp_pulses));
      chk($sformatf("v%0d_done", idx), 32'(seen_done), 32'(v.exp_done));
      chk($sformatf("v%0d_err", idx), 32'(seen_err), 32'(v.exp_err));
      chk($sformatf("v%0d_err_code", idx), 32'(err_code), 32'(v.exp_code));
      chk($sformatf("v%0d_balance", idx), 32'(balance), 32'(v.exp_bal));
   endtask

   initial begin
      int pulses;

      //          rst rq dep inv amt     q      damt    code  pul done err bal
      vecs[0]  = '{1, 1, 0, 1, 8'd0,   4'd2,  8'd0,   2'd1, 0,  0,   1,  16'd500};
      vecs[1]  = '{0, 1, 0, 0, 8'd100, 4'd6,  8'd0,   2'd3, 0,  0,   1,  16'd500};
      vecs[2]  = '{0, 0, 1, 0, 8'd0,   4'd0,  8'd100, 2'd3, 0,  0,   0,  16'd600};
      vecs[3]  = '{0, 1, 0, 0, 8'd100, 4'd6,  8'd0,   2'd0, 6,  1,   0,  16'd0};
      vecs[4]  = '{1, 1, 0, 0, 8'd50,  4'd0,  8'd0,   2'd2, 0,  0,   1,  16'd500};
      vecs[5]  = '{0, 1, 1, 0, 8'd10,  4'd5,  8'd50,  2'd0, 5,  1,   0,  16'd450};
      vecs[6]  = '{0, 1, 0, 0, 8'd1,   4'd15, 8'd0,   2'd0, 15, 1,   0,  16'd435};
      vecs[7]  = '{0, 1, 0, 0, 8'd5,   4'd1,  8'd0,   2'd0, 1,  1,   0,  16'd430};
      vecs[8]  = '{0, 1, 0, 1, 8'd20,  4'd1,  8'd0,   2'd1, 0,  0,   1,  16'd430};
      vecs[9]  = '{0, 1, 0, 0, 8'd0,   4'd3,  8'd0,   2'd2, 0,  0,   1,  16'd430};
      vecs[10] = '{0, 1, 0, 0, 8'd50,  4'd9,  8'd0,   2'd3, 0,  0,   1,  16'd430};
      vecs[11] = '{1, 1, 0, 0, 8'd100, 4'd5,  8'd0,   2'd0, 5,  1,   0,  16'd0};

      idle_inputs();
      rst_n = 1'b1;
      do_reset();

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pulse", 32'(bill_pulse), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_bill_val", 32'(bill_val), 32'd0);
      chk("rst_remaining", 32'(remaining), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      chk("rst_balance", 32'(balance), 32'd500);

      // cycle-exact 20 x 3 withdrawal
      amount = 8'd20; qty = 4'd3; req = 1'b1;
      tick();
      idle_inputs();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         chk($sformatf("seq1_c%0d_pulse", c + 1), 32'(bill_pulse), 32'(exp_pulse[c]));
         chk($sformatf("seq1_c%0d_done", c + 1), 32'(done), 32'(exp_done[c]));
         chk($sformatf("seq1_c%0d_busy", c + 1), 32'(busy), 32'(exp_busy[c]));
         chk($sformatf("seq1_c%0d_rem", c + 1), 32'(remaining), 32'(exp_rem[c]));
         chk($sformatf("seq1_c%0d_bal", c + 1), 32'(balance), 32'(exp_bal[c]));
      end
      chk("seq1_bill_val", 32'(bill_val), 32'd20);

      // error-path timing: err in cycle 2, busy drops in cycle 3
      do_reset();
      invalid = 1'b1; amount = 8'd0; qty = 4'd2; req = 1'b1;
      tick();
      idle_inputs();
      chk("errt_c1_busy", 32'(busy), 32'd1);
      chk("errt_c1_err", 32'(err), 32'd0);
      tick();
      chk("errt_c2_err", 32'(err), 32'd1);
      chk("errt_c2_code", 32'(err_code), 32'd1);
      chk("errt_c2_pulse", 32'(bill_pulse), 32'd0);
      tick();
      chk("errt_c3_busy", 32'(busy), 32'd0);
      chk("errt_c3_err", 32'(err), 32'd0);
      chk("errt_c3_bal", 32'(balance), 32'd500);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // reset during the second gap of a 20 x 4 withdrawal
      do_reset();
      amount = 8'd20; qty = 4'd4; req = 1'b1;
      tick();
      idle_inputs();
      tick();
      chk("mrst_c2_pulse", 32'(bill_pulse), 32'd1);
      tick();
      tick();
      tick();
      chk("mrst_c5_pulse", 32'(bill_pulse), 32'd1);
      chk("mrst_c5_bal", 32'(balance), 32'd420);
      tick();
      chk("mrst_c6_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_bal", 32'(balance), 32'd500);
      chk("mrst_pulse", 32'(bill_pulse), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_err", 32'(err), 32'd0);
      chk("mrst_rem", 32'(remaining), 32'd0);
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bill_pulse) pulses++;
      end
      chk("mrst_no_pulses", 32'(pulses), 32'd0);
      chk("mrst_idle", 32'(busy), 32'd0);

      // drive balance to 65500 (500 + 254*255 + 230), then saturate
      do_reset();
      dep_en = 1'b1; dep_amt = 8'd255;
      for (int i = 0; i < 254; i++) tick();
      dep_amt = 8'd230;
      tick();
      dep_en = 1'b0;
      chk("sat_pre", 32'(balance), 32'd65500);
      dep_en = 1'b1; dep_amt = 8'd100;
      tick();
      dep_en = 1'b0;
      chk("sat_100", 32'(balance), 32'd65535);
      dep_en = 1'b1; dep_amt = 8'd1;
      tick();
      dep_en = 1'b0;
      chk("sat_hold", 32'(balance), 32'd65535);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
